inst_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/sat_counter.sv | 38 +++
 rtl/inst_fetch.sv | 121 ++++++++++++
 tb/tb_inst_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default widths, the PC type and the fetch FSM
// state encoding. The lookup table and the instruction ROM use the same
// package, so branch targets and ROM addresses always have the same width.
package fetch_pkg;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear and a count enable.
// Reset is synchronous and active-low. Clear takes priority over enable.
// Once the counter reaches all-ones it holds there until it is cleared.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, otherwise increment unless saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencer. It runs an IDLE/RUN/DONE handshake,
// takes absolute branch targets from the external lookup table, and counts
// the RUN cycles that were not stalled.
// Priority inside RUN is Stall > Halt > BranchAbs > increment.
// Optional macro FETCH_BRANCH_CNT_EN adds a BranchCount output. That output
// counts the taken branches that were neither stalled nor overridden by Halt.
module inst_fetch #(
    parameter int                  PC_W     = fetch_pkg::PC_W,
    parameter logic [PC_W-1:0]     START_PC = '0,
    parameter int                  CNT_W    = fetch_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchAbs,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCounter,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount
`ifdef FETCH_BRANCH_CNT_EN
    ,
    output logic [CNT_W-1:0] BranchCount
`endif
);

    import fetch_pkg::*;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            running_q;
    logic            done_q;

    // A Start seen in IDLE begins a fresh run, so it clears the counters.
    logic run_start;
    // Only RUN cycles without a stall retire a fetch.
    logic retire;

    assign run_start = (state_q == IDLE) && Start;
    assign retire    = (state_q == RUN) && !Stall;

    // Next state and next PC. The PC is parked at START_PC outside a run,
    // except in DONE, where it keeps pointing at the halt instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                pc_d = START_PC;
                if (Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        state_d = DONE;
                    end else if (BranchAbs) begin
                        pc_d = Target;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Wait for Start to fall, so that a held Start cannot
                // restart the run. A restart has to pass through IDLE.
                if (!Start) begin
                    state_d = IDLE;
                    pc_d    = START_PC;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    // State, PC and registered status decodes, with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk     (Clk),
        .rst_ni  (Reset),
        .clr_i   (run_start),
        .en_i    (retire),
        .count_o (InstCount)
    );

`ifdef FETCH_BRANCH_CNT_EN
    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk     (Clk),
        .rst_ni  (Reset),
        .clr_i   (run_start),
        .en_i    (retire && !Halt && BranchAbs),
        .count_o (BranchCount)
    );
`endif

    assign ProgCounter = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. A second instance with a 3-bit counter
// and a non-zero START_PC receives the same stimulus and is used for the
// saturation and start-address scenario.
// Optional macro FETCH_BRANCH_CNT_EN enables the BranchCount scenario.
`timescale 1ns/1ps
module tb_inst_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic        Halt;
    logic        BranchAbs;
    logic [9:0]  Target;
    logic [9:0]  ProgCounter;
    logic        Running;
    logic        Done;
    logic [15:0] InstCount;
    logic [9:0]  pc_s;
    logic        running_s;
    logic        done_s;
    logic [2:0]  inst_s;
`ifdef FETCH_BRANCH_CNT_EN
    logic [15:0] BranchCount;
    logic [2:0]  branch_s;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    inst_fetch #(.PC_W(10), .START_PC(10'h000), .CNT_W(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .Halt        (Halt),
        .BranchAbs   (BranchAbs),
        .Target      (Target),
        .ProgCounter (ProgCounter),
        .Running     (Running),
        .Done        (Done),
        .InstCount   (InstCount)
`ifdef FETCH_BRANCH_CNT_EN
        ,
        .BranchCount (BranchCount)
`endif
    );

    inst_fetch #(.PC_W(10), .START_PC(10'h100), .CNT_W(3)) dut_s (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .Halt        (Halt),
        .BranchAbs   (BranchAbs),
        .Target      (Target),
        .ProgCounter (pc_s),
        .Running     (running_s),
        .Done        (done_s),
        .InstCount   (inst_s)
`ifdef FETCH_BRANCH_CNT_EN
        ,
        .BranchCount (branch_s)
`endif
    );

    // Advance one rising edge and settle 1 ns past it before sampling or driving.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Halt = 1'b0;
        BranchAbs = 1'b0; Target = '0;
        step(); step();
        n_checks++;
        if ({ProgCounter, Running, Done, InstCount} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state: pc=%0d run=%0b done=%0b cnt=%0d expected 0/0/0/0",
                     ProgCounter, Running, Done, InstCount);
        end
        Reset = 1'b1;
        step(); step(); step();
        n_checks++;
        if ({ProgCounter, Running, Done, InstCount} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL idle_hold: pc=%0d run=%0b done=%0b cnt=%0d expected 0/0/0/0",
                     ProgCounter, Running, Done, InstCount);
        end
        $display("test_reset: pc=%0d run=%0b done=%0b cnt=%0d", ProgCounter, Running, Done, InstCount);
    endtask

    task automatic test_run();
        Start = 1'b1;
        step();
        Start = 1'b0;
        n_checks++;
        if ({ProgCounter, Running, InstCount} !== {10'd0, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL run_entry: pc=%0d run=%0b cnt=%0d expected 0/1/0",
                     ProgCounter, Running, InstCount);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++;
            if (ProgCounter !== 10'(i)) begin
                n_fail++;
                $display("FAIL run_pc_%0d: got %0d expected %0d", i, ProgCounter, i);
            end
        end
        n_checks++;
        if ({InstCount, Running} !== {16'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL run_count: cnt=%0d run=%0b expected 5/1", InstCount, Running);
        end
        $display("test_run: pc=%0d cnt=%0d", ProgCounter, InstCount);
    endtask

    task automatic test_branch_stall();
        step(); step();                          // PC 7, count 7
        BranchAbs = 1'b1; Target = 10'b0000010011;
        step();
        BranchAbs = 1'b0;
        n_checks++;
        if ({ProgCounter, InstCount} !== {10'd19, 16'd8}) begin
            n_fail++;
            $display("FAIL branch: pc=%0d cnt=%0d expected 19/8", ProgCounter, InstCount);
        end
        Stall = 1'b1;
        step();
        n_checks++;
        if ({ProgCounter, InstCount} !== {10'd19, 16'd8}) begin
            n_fail++;
            $display("FAIL stall: pc=%0d cnt=%0d expected 19/8", ProgCounter, InstCount);
        end
        Halt = 1'b1;                             // stall still outranks halt
        step();
        Halt = 1'b0; Stall = 1'b0;
        n_checks++;
        if ({ProgCounter, InstCount, Running, Done} !== {10'd19, 16'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_over_halt: pc=%0d cnt=%0d run=%0b done=%0b expected 19/8/1/0",
                     ProgCounter, InstCount, Running, Done);
        end
        $display("test_branch_stall: pc=%0d cnt=%0d", ProgCounter, InstCount);
    endtask

    task automatic test_halt_restart();
        BranchAbs = 1'b1; Target = 10'h03C;
        step();                                  // PC 0x3C, count 9
        Halt = 1'b1; Target = 10'h155;
        step();
        Halt = 1'b0; BranchAbs = 1'b0;
        n_checks++;
        if ({ProgCounter, InstCount, Running, Done} !== {10'h03C, 16'd10, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL halt_over_branch: pc=%0h cnt=%0d run=%0b done=%0b expected 3c/10/0/1",
                     ProgCounter, InstCount, Running, Done);
        end
        Start = 1'b1;
        step(); step();
        n_checks++;
        if ({ProgCounter, InstCount, Done} !== {10'h03C, 16'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL done_hold: pc=%0h cnt=%0d done=%0b expected 3c/10/1",
                     ProgCounter, InstCount, Done);
        end
        Start = 1'b0;
        step();
        n_checks++;
        if ({ProgCounter, Running, Done, InstCount} !== {10'd0, 1'b0, 1'b0, 16'd10}) begin
            n_fail++;
            $display("FAIL done_to_idle: pc=%0d run=%0b done=%0b cnt=%0d expected 0/0/0/10",
                     ProgCounter, Running, Done, InstCount);
        end
        BranchAbs = 1'b1; Target = 10'h123;      // ignored in IDLE
        step();
        BranchAbs = 1'b0;
        n_checks++;
        if ({ProgCounter, Running} !== {10'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_ignore: pc=%0h run=%0b expected 0/0", ProgCounter, Running);
        end
        Start = 1'b1;
        step();
        Start = 1'b0;
        n_checks++;
        if ({ProgCounter, InstCount, Running} !== {10'd0, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL restart: pc=%0d cnt=%0d run=%0b expected 0/0/1",
                     ProgCounter, InstCount, Running);
        end
        $display("test_halt_restart: pc=%0d cnt=%0d run=%0b", ProgCounter, InstCount, Running);
    endtask

    task automatic test_wrap_reset();
        BranchAbs = 1'b1; Target = 10'h3FF;
        step();
        BranchAbs = 1'b0;
        n_checks++;
        if ({ProgCounter, InstCount} !== {10'h3FF, 16'd1}) begin
            n_fail++;
            $display("FAIL wrap_load: pc=%0h cnt=%0d expected 3ff/1", ProgCounter, InstCount);
        end
        step();
        n_checks++;
        if ({ProgCounter, InstCount} !== {10'd0, 16'd2}) begin
            n_fail++;
            $display("FAIL wrap: pc=%0h cnt=%0d expected 0/2", ProgCounter, InstCount);
        end
        step();                                  // PC 1, count 3
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        n_checks++;
        if ({ProgCounter, Running, Done, InstCount} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL midrun_reset: pc=%0d run=%0b done=%0b cnt=%0d expected 0/0/0/0",
                     ProgCounter, Running, Done, InstCount);
        end
        $display("test_wrap_reset: pc=%0d run=%0b cnt=%0d", ProgCounter, Running, InstCount);
    endtask

    task automatic test_saturation();
        Start = 1'b1;
        step();
        Start = 1'b0;
        n_checks++;
        if ({pc_s, running_s, inst_s} !== {10'h100, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL start_pc: pc=%0h run=%0b cnt=%0d expected 100/1/0", pc_s, running_s, inst_s);
        end
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if ({pc_s, inst_s} !== {10'h109, 3'd7}) begin
            n_fail++;
            $display("FAIL saturate: pc=%0h cnt=%0d expected 109/7", pc_s, inst_s);
        end
        n_checks++;
        if (InstCount !== 16'd9) begin
            n_fail++;
            $display("FAIL wide_count: got %0d expected 9", InstCount);
        end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        $display("test_saturation: pc_s=%0h cnt_s=%0d", pc_s, inst_s);
    endtask

`ifdef FETCH_BRANCH_CNT_EN
    task automatic test_branch_count();
        Start = 1'b1;
        step();
        Start = 1'b0;
        BranchAbs = 1'b1; Target = 10'd5;
        step();
        Stall = 1'b1;
        step();
        Stall = 1'b0; Target = 10'd9;
        step();
        BranchAbs = 1'b0;
        n_checks++;
        if ({BranchCount, ProgCounter, InstCount} !== {16'd2, 10'd9, 16'd2}) begin
            n_fail++;
            $display("FAIL branch_count: bc=%0d pc=%0d cnt=%0d expected 2/9/2",
                     BranchCount, ProgCounter, InstCount);
        end
        Halt = 1'b1; BranchAbs = 1'b1;
        step();
        Halt = 1'b0; BranchAbs = 1'b0;
        n_checks++;
        if ({BranchCount, Done} !== {16'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_count_halt: bc=%0d done=%0b expected 2/1", BranchCount, Done);
        end
        $display("test_branch_count: bc=%0d", BranchCount);
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_branch_stall();
        test_halt_restart();
        test_wrap_reset();
        test_saturation();
`ifdef FETCH_BRANCH_CNT_EN
        test_branch_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
